scan_decoder: RTL and testbench



---
 rtl/scan_decoder.sv | 78 +++++++
 tb/tb_scan_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, output polarity select and
// an auto-scan mode whose index walks every output at a prescaled rate.
module scan_decoder #(
   parameter int unsigned N          = 3,
   parameter int unsigned DIV        = 1,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              load,
   input  logic [N-1:0]      I,
   output logic [2**N-1:0]   Y,
   output logic [N-1:0]      idx,
   output logic              wrap
);

   localparam int unsigned W  = 2 ** N;
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [N-1:0]  IDX_LAST = '1;
   localparam logic [W-1:0]  Y_IDLE   = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0] pre;
   logic [PW-1:0] pre_nxt;
   logic [N-1:0]  idx_nxt;
   logic          wrap_nxt;
   logic          act_nxt;
   logic [W-1:0]  hot;
   logic [W-1:0]  y_nxt;

   // Next index / prescaler / wrap; load and direct mode share the preset path
   always_comb begin
      idx_nxt  = idx;
      pre_nxt  = pre;
      wrap_nxt = 1'b0;
      act_nxt  = 1'b0;
      if (en) begin
         act_nxt = 1'b1;
         if (!mode || load) begin
            idx_nxt = I;
            pre_nxt = '0;
         end else if (pre == PRE_LAST) begin
            idx_nxt  = idx + N'(1);
            pre_nxt  = '0;
            wrap_nxt = (idx == IDX_LAST);
         end else begin
            pre_nxt = pre + PW'(1);
         end
      end
   end

   // Decode the next index so Y and idx always agree in the same cycle
   always_comb begin
      hot   = W'(1) << idx_nxt;
      y_nxt = Y_IDLE;
      if (act_nxt) begin
         y_nxt = (ACTIVE_LOW != 0) ? ~hot : hot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx  <= '0;
         pre  <= '0;
         wrap <= 1'b0;
         Y    <= Y_IDLE;
      end else begin
         idx  <= idx_nxt;
         pre  <= pre_nxt;
         wrap <= wrap_nxt;
         Y    <= y_nxt;
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: two instances (DIV=2 active-high, DIV=1 active-low)
// on shared inputs, checked against a per-instance arithmetic reference model.
module tb_scan_decoder;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic       load;
   logic [2:0] I;

   logic [7:0] y_a;
   logic [2:0] idx_a;
   logic       wrap_a;
   logic [7:0] y_b;
   logic [2:0] idx_b;
   logic       wrap_b;

   int compared   = 0;
   int mismatched = 0;

   // Reference state per instance: 0 = DIV 2 active-high, 1 = DIV 1 active-low
   int m_idx[2];
   int m_cnt[2];
   bit m_act[2];
   bit m_wrap[2];
   int m_div[2] = '{2, 1};
   bit m_low[2] = '{1'b0, 1'b1};

   scan_decoder #(.N(3), .DIV(2), .ACTIVE_LOW(0)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .I(I),
      .Y(y_a), .idx(idx_a), .wrap(wrap_a)
   );

   scan_decoder #(.N(3), .DIV(1), .ACTIVE_LOW(1)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .I(I),
      .Y(y_b), .idx(idx_b), .wrap(wrap_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_y(input int u);
      logic [7:0] v;
      v = m_act[u] ? (8'd1 << m_idx[u]) : 8'd0;
      return m_low[u] ? ~v : v;
   endfunction

   // Apply one cycle of inputs, advance the model, then compare all outputs
   task automatic step(input logic r, input logic e, input logic m,
                       input logic l, input logic [2:0] sel);
      rst  = r;
      en   = e;
      mode = m;
      load = l;
      I    = sel;
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
         if (r) begin
            m_idx[u] = 0; m_cnt[u] = 0; m_act[u] = 1'b0; m_wrap[u] = 1'b0;
         end else if (!e) begin
            m_act[u] = 1'b0; m_wrap[u] = 1'b0;
         end else if (!m || l) begin
            m_idx[u] = int'(sel); m_cnt[u] = 0; m_act[u] = 1'b1; m_wrap[u] = 1'b0;
         end else begin
            m_act[u] = 1'b1;
            m_cnt[u] = m_cnt[u] + 1;
            m_wrap[u] = 1'b0;
            if (m_cnt[u] == m_div[u]) begin
               m_cnt[u]  = 0;
               m_wrap[u] = (m_idx[u] == 7);
               m_idx[u]  = (m_idx[u] + 1) % 8;
            end
         end
      end
      #1;
      check("y_a",    y_a,            exp_y(0));
      check("idx_a",  8'(idx_a),      8'(m_idx[0]));
      check("wrap_a", 8'(wrap_a),     8'(m_wrap[0]));
      check("y_b",    y_b,            exp_y(1));
      check("idx_b",  8'(idx_b),      8'(m_idx[1]));
      check("wrap_b", 8'(wrap_b),     8'(m_wrap[1]));
   endtask

   int scan_seq[6] = '{6, 7, 7, 0, 0, 1};

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; I = 3'd5;

      // Reset held two cycles with en=1 and I=5
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
      check("rst_y_a", y_a, 8'h00);
      check("rst_y_b", y_b, 8'hFF);
      check("rst_idx_a", 8'(idx_a), 8'd0);

      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
      check("release_y_a", y_a, 8'b0010_0000);

      // Direct sweep
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 3'(i));
         check("sweep_wrap_a", 8'(wrap_a), 8'd0);
      end

      // Polarity on the active-low instance
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
      check("pol_direct_y_b", y_b, 8'b1111_1011);
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
      check("pol_disabled_y_b", y_b, 8'hFF);

      // Scan from idx 6 with DIV=2
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd6);
      check("scan_start_idx_a", 8'(idx_a), 8'd6);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
         check("scan_seq_idx_a", 8'(idx_a), 8'(scan_seq[k]));
         check("scan_seq_wrap_a", 8'(wrap_a), (k == 3) ? 8'd1 : 8'd0);
      end

      // Load on a tick cycle at idx 7 overrides the wrap
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd7);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
      check("load_idx_a", 8'(idx_a), 8'd3);
      check("load_wrap_a", 8'(wrap_a), 8'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      check("load_hold_idx_a", 8'(idx_a), 8'd3);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      check("load_tick_idx_a", 8'(idx_a), 8'd4);

      // Enable freeze mid-scan
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
         check("freeze_y_a", y_a, 8'h00);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      end

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0),
              3'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
